ir_sample_filter: RTL
=====================

Name: ir_sample_filter

Overview:
Conditions raw IR-ADC samples before the ADC-to-distance lookup and the wall-follower PID loop. It runs a power-of-two moving-average window over signed ADC samples and rejects single-sample spikes against the current average. Sustained steps are re-seeded rather than rejected forever. Output is a filtered sample with a one-cycle valid strobe that replaces the raw ADC word feeding the distance lookup.

Parameters:
DATA_WIDTH, 16, width of signed input/output samples
WINDOW_LOG2, 3, log2 of averaging window length (window N = 2^WINDOW_LOG2, legal 1..6)
MAX_STEP, 4096, spike threshold on |sample - avg_out|; 0 disables rejection

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
en  in  1  filter enable; when low, samples ignored and all state held
flush  in  1  synchronous clear of window contents (same effect as reset)
sample_valid  in  1  one-cycle strobe qualifying sample_in
sample_in  in  DATA_WIDTH  signed raw ADC sample
avg_valid  out  1  one-cycle strobe, avg_out updated this cycle
avg_out  out  DATA_WIDTH  signed windowed average
primed  out  1  high once N samples have entered the window
rejected  out  1  one-cycle strobe, sample substituted as spike

Behaviour:
- Reset/flush: buffer entries, running sum, write pointer, fill count and reject count cleared to 0. avg_out=0, avg_valid=0, primed=0, rejected=0. Flush is also honoured while en=0. Flush in the same cycle as sample_valid: flush wins and the sample is dropped. Reset or flush mid-pipeline discards in-flight samples; no avg_valid follows.
- Accept: sample taken when sample_valid & en & ~flush at cycle T. Back-to-back samples every cycle are legal, with full throughput.
- Pipeline: stage 1 (T+1) registers the sample and the spike decision. Stage 2 (T+2) updates buffer and sum and drives avg_out/avg_valid. Latency is exactly 2 cycles.
- Fill phase (primed=0):
  - Sample written to buffer[wr_ptr]; sum += sample; fill count increments.
  - No spike check and no avg_valid.
  - At the Nth sample, primed rises in the same cycle as the first avg_valid.
- Run phase (primed=1):
  - Compute d = |sample - avg_out| using the avg_out value at stage-1 time, with DATA_WIDTH+1 bit arithmetic.
  - If MAX_STEP != 0 and d > MAX_STEP, the sample is a spike: the value written is avg_out, rejected pulses at T+2, and reject count increments.
  - Otherwise the sample itself is written and reject count clears to 0.
- Re-seed: if a spike arrives while reject count = N-1 (i.e. the Nth consecutive spike):
  - All buffer entries are set to that sample in parallel; sum = sample << WINDOW_LOG2.
  - Reject count clears; rejected is NOT pulsed.
  - avg_out = that sample.
- Sum update: sum_next = sum + new - buffer[wr_ptr]. Sum register is DATA_WIDTH+WINDOW_LOG2 bits signed and never overflows.
- avg_out = sum_next >>> WINDOW_LOG2 (arithmetic shift, floor toward -inf).
- wr_ptr wraps N-1 -> 0.
- A dependent sample at T+1 uses the avg_out produced at T+2 of the previous sample via a stage-2 to stage-1 bypass, so the decision always uses the newest average.
- en low: incoming samples ignored; in-flight samples still complete.

Decomposition:
- Package ir_filter_pkg: constant WINDOW_N = 2**WINDOW_LOG2 helper function, SUM_WIDTH function (DATA_WIDTH+WINDOW_LOG2), and typedef of the signed sample type used here and by the distance lookup.
- Sub-module spike_gate: combinational |a-b| > threshold comparator plus the consecutive-reject counter and re-seed decision. Keeps the window/sum datapath separate.

Test Plan:
- Reset, then 8 samples of 1000 (WINDOW_LOG2=3) -> no avg_valid for samples 1-7; at 8th sample T+2: primed=1, avg_valid=1, avg_out=1000.
- Primed at 1000, feed 1080 -> avg_out=1010. Feed 1080 seven more times -> avg_out reaches 1080 on the 8th. Confirm wr_ptr wrap with no glitch.
- Window filled with -1 except one 0 (sum=-7) -> avg_out=-1 (floor). Full window of 0x7FFF -> avg_out=32767, no overflow.
- Primed at 1000, MAX_STEP=4096, sample 6000 -> rejected=1 at T+2, avg_out stays 1000. Sample 5096 -> accepted, no reject.
- Primed at 1000, eight consecutive samples of 6000 -> rejected on first 7; 8th re-seeds, avg_out=6000, rejected=0. Next sample 6000 -> avg_out=6000.
- flush asserted together with sample_valid mid-run -> sample dropped, primed=0, avg_out=0. Samples back-to-back every cycle afterwards -> each produces avg_valid exactly 2 cycles later once primed. en=0 samples produce nothing.

Source files
------------

// File: rtl/ir_filter_pkg.sv
// rtl/ir_filter_pkg.sv - shared window/sum sizing helpers and the IR sample type
package ir_filter_pkg;

  localparam int IR_DATA_WIDTH = 16;

  // Signed raw/filtered IR sample as seen by the filter and the distance lookup.
  typedef logic signed [IR_DATA_WIDTH-1:0] ir_sample_t;

  function automatic int window_n(input int window_log2);
    return 1 << window_log2;
  endfunction

  function automatic int sum_width(input int data_width, input int window_log2);
    return data_width + window_log2;
  endfunction

endpackage

// File: rtl/ir_sample_filter_spike_gate.sv
// rtl/ir_sample_filter_spike_gate.sv - spike comparator, consecutive-reject counter and re-seed decision
module spike_gate
  import ir_filter_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_LOG2 = 3,
  parameter int MAX_STEP    = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         check_en,
  input  logic signed [DATA_WIDTH-1:0] sample,
  input  logic signed [DATA_WIDTH-1:0] avg,
  input  logic                         commit_valid,
  input  logic                         commit_spike,
  output logic                         spike,
  output logic                         reseed
);

  localparam int N = window_n(WINDOW_LOG2);
  localparam logic [WINDOW_LOG2-1:0] LAST = WINDOW_LOG2'(N - 1);
  localparam logic [DATA_WIDTH:0]    STEP = (DATA_WIDTH + 1)'(MAX_STEP);

  logic [WINDOW_LOG2-1:0]      rej_cnt_q, rej_cnt_d;
  logic signed [DATA_WIDTH:0]  diff;
  logic [DATA_WIDTH:0]         mag;

  // Counter next value is also the bypassed count seen by the sample being decided now.
  always_comb begin
    rej_cnt_d = rej_cnt_q;
    if (clear) begin
      rej_cnt_d = '0;
    end else if (commit_valid) begin
      rej_cnt_d = commit_spike ? rej_cnt_q + WINDOW_LOG2'(1) : '0;
    end
  end

  always_comb begin
    diff   = $signed({sample[DATA_WIDTH-1], sample}) - $signed({avg[DATA_WIDTH-1], avg});
    mag    = diff[DATA_WIDTH] ? $unsigned(-diff) : $unsigned(diff);
    spike  = check_en && (MAX_STEP != 0) && (mag > STEP);
    reseed = spike && (rej_cnt_d == LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rej_cnt_q <= '0;
    end else begin
      rej_cnt_q <= rej_cnt_d;
    end
  end

endmodule

// File: rtl/ir_sample_filter.sv
// rtl/ir_sample_filter.sv - two-stage moving-average IR sample filter with spike rejection and re-seed
module ir_sample_filter
  import ir_filter_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int WINDOW_LOG2 = 3,
  parameter int MAX_STEP    = 4096
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         flush,
  input  logic                         sample_valid,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  output logic                         avg_valid,
  output logic signed [DATA_WIDTH-1:0] avg_out,
  output logic                         primed,
  output logic                         rejected
);

  localparam int N  = window_n(WINDOW_LOG2);
  localparam int SW = sum_width(DATA_WIDTH, WINDOW_LOG2);
  localparam logic [WINDOW_LOG2-1:0] LAST = WINDOW_LOG2'(N - 1);

  typedef logic signed [DATA_WIDTH-1:0] sample_t;
  typedef logic signed [SW-1:0]         sum_t;

  sample_t                win_q [N];
  sample_t                win_d [N];
  sum_t                   sum_q, sum_d;
  logic [WINDOW_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [WINDOW_LOG2-1:0] fill_cnt_q, fill_cnt_d;
  logic                   primed_q, primed_d;
  sample_t                avg_q, avg_d;
  logic                   avg_valid_q, avg_valid_d;
  logic                   rejected_q, rejected_d;
  logic                   s1_valid_q, s1_valid_d;
  sample_t                s1_sample_q, s1_sample_d;
  logic                   s1_spike_q, s1_spike_d;
  logic                   s1_reseed_q, s1_reseed_d;
  logic                   accept, gate_spike, gate_reseed;
  sample_t                wr_val;

  assign accept = sample_valid && en && !flush;

  // Decision uses primed_d/avg_d so a back-to-back sample sees the average its predecessor is producing.
  spike_gate #(
    .DATA_WIDTH  (DATA_WIDTH),
    .WINDOW_LOG2 (WINDOW_LOG2),
    .MAX_STEP    (MAX_STEP)
  ) u_spike_gate (
    .clk          (clk),
    .reset        (reset),
    .clear        (flush),
    .check_en     (primed_d),
    .sample       (sample_in),
    .avg          (avg_d),
    .commit_valid (s1_valid_q),
    .commit_spike (s1_spike_q),
    .spike        (gate_spike),
    .reseed       (gate_reseed)
  );

  always_comb begin
    s1_valid_d  = accept;
    s1_sample_d = sample_in;
    s1_spike_d  = gate_spike && !gate_reseed;
    s1_reseed_d = gate_reseed;
    if (flush) begin
      s1_valid_d  = 1'b0;
      s1_sample_d = '0;
      s1_spike_d  = 1'b0;
      s1_reseed_d = 1'b0;
    end
  end

  always_comb begin
    win_d       = win_q;
    sum_d       = sum_q;
    wr_ptr_d    = wr_ptr_q;
    fill_cnt_d  = fill_cnt_q;
    primed_d    = primed_q;
    avg_d       = avg_q;
    avg_valid_d = 1'b0;
    rejected_d  = 1'b0;
    wr_val      = s1_spike_q ? avg_q : s1_sample_q;
    if (s1_valid_q) begin
      if (s1_reseed_q) begin
        for (int i = 0; i < N; i++) begin
          win_d[i] = s1_sample_q;
        end
        sum_d       = sum_t'(s1_sample_q) <<< WINDOW_LOG2;
        avg_d       = s1_sample_q;
        avg_valid_d = 1'b1;
      end else begin
        win_d[wr_ptr_q] = wr_val;
        sum_d           = sum_q + sum_t'(wr_val) - sum_t'(win_q[wr_ptr_q]);
        wr_ptr_d        = wr_ptr_q + WINDOW_LOG2'(1);
        rejected_d      = s1_spike_q;
        if (primed_q) begin
          avg_valid_d = 1'b1;
        end else begin
          fill_cnt_d = fill_cnt_q + WINDOW_LOG2'(1);
          if (fill_cnt_q == LAST) begin
            primed_d    = 1'b1;
            avg_valid_d = 1'b1;
          end
        end
        if (avg_valid_d) begin
          avg_d = sample_t'(sum_d >>> WINDOW_LOG2);
        end
      end
    end
    if (flush) begin
      for (int i = 0; i < N; i++) begin
        win_d[i] = '0;
      end
      sum_d       = '0;
      wr_ptr_d    = '0;
      fill_cnt_d  = '0;
      primed_d    = 1'b0;
      avg_d       = '0;
      avg_valid_d = 1'b0;
      rejected_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        win_q[i] <= '0;
      end
      sum_q       <= '0;
      wr_ptr_q    <= '0;
      fill_cnt_q  <= '0;
      primed_q    <= 1'b0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
      rejected_q  <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_sample_q <= '0;
      s1_spike_q  <= 1'b0;
      s1_reseed_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        win_q[i] <= win_d[i];
      end
      sum_q       <= sum_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_cnt_q  <= fill_cnt_d;
      primed_q    <= primed_d;
      avg_q       <= avg_d;
      avg_valid_q <= avg_valid_d;
      rejected_q  <= rejected_d;
      s1_valid_q  <= s1_valid_d;
      s1_sample_q <= s1_sample_d;
      s1_spike_q  <= s1_spike_d;
      s1_reseed_q <= s1_reseed_d;
    end
  end

  assign avg_valid = avg_valid_q;
  assign avg_out   = avg_q;
  assign primed    = primed_q;
  assign rejected  = rejected_q;

endmodule
